pmem_line_responder: RTL and testbench

- Responder (memory) end of the 128-bit line interface used by the L1 instruction and data caches (lc3b_datbus).
- Accepts one line read or line write at a time and returns pmem_resp after a fixed, parameterised latency.
- Backed by an on-chip line array, so the core can be simulated and synthesised without an external memory model.
- Sits below the cache arbiter; it is the slave for every physical-memory transaction.

---
 rtl/pmem_line_responder.sv | 179 +++++++++++++++++
 tb/tb_pmem_line_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
// Single-port line memory responder for the 128-bit cache line bus, fixed-latency handshake.
// Optional statistics counters are enabled with `define PMEM_STATS_EN.
module pmem_line_responder #(
  parameter int LINES   = 256,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_error
`ifdef PMEM_STATS_EN
  ,
  output logic [15:0]  stat_reads,
  output logic [15:0]  stat_writes
`endif
);

  localparam int         IDX_W    = $clog2(LINES);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic               op_write_r, op_write_s;
  logic [127:0]       wdata_r, wdata_s;
  logic               error_r, error_s;
  logic               resp_r;
  logic [127:0]       rdata_r;
  logic               req_s;
  logic               unused_addr_s;
  logic [127:0]       mem_r [LINES];

  assign req_s         = pmem_read | pmem_write;
  // Offset and wrap bits of the address never select a line.
  assign unused_addr_s = ^pmem_address;

  // Next-state, capture and error-flag logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    op_write_s = op_write_r;
    wdata_s    = wdata_r;
    error_s    = error_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          idx_s      = pmem_address[IDX_W+3:4];
          op_write_s = pmem_write;
          wdata_s    = pmem_wdata;
          cnt_s      = CNT_LOAD;
          if (pmem_read && pmem_write) begin
            error_s = 1'b1;
          end else begin
            error_s = error_r;
          end
          state_s = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!req_s) begin
          // Initiator gave up: abort without response or array update.
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
          error_s = 1'b1;
        end else begin
          if (pmem_write != op_write_r) begin
            error_s = 1'b1;
          end else begin
            error_s = error_r;
          end
          cnt_s = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_BUSY;
          end
        end
      end
      ST_RESP: begin
        state_s = ST_TURN;
        cnt_s   = 4'd0;
      end
      ST_TURN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Control state, captured request and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      idx_r      <= '0;
      op_write_r <= 1'b0;
      wdata_r    <= 128'd0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      op_write_r <= op_write_s;
      wdata_r    <= wdata_s;
      error_r    <= error_s;
    end
  end

  // Registered response pulse and read data, both launched on entry to RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_r  <= 1'b0;
      rdata_r <= 128'd0;
    end else begin
      resp_r <= (state_s == ST_RESP);
      if ((state_s == ST_RESP) && !op_write_s) begin
        rdata_r <= mem_r[idx_s];
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Line array; contents survive reset and are written at the end of RESP.
  always_ff @(posedge clk) begin
    if ((state_r == ST_RESP) && op_write_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  assign pmem_rdata = rdata_r;
  assign pmem_resp  = resp_r;
  assign pmem_error = error_r;

`ifdef PMEM_STATS_EN
  logic [15:0] stat_reads_r;
  logic [15:0] stat_writes_r;

  // Saturating completion counters, stepped in the RESP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads_r  <= 16'd0;
      stat_writes_r <= 16'd0;
    end else if (state_r == ST_RESP) begin
      if (op_write_r) begin
        if (stat_writes_r != 16'hFFFF) begin
          stat_writes_r <= stat_writes_r + 16'd1;
        end
      end else begin
        if (stat_reads_r != 16'hFFFF) begin
          stat_reads_r <= stat_reads_r + 16'd1;
        end
      end
    end
  end

  assign stat_reads  = stat_reads_r;
  assign stat_writes = stat_writes_r;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench for pmem_line_responder: randomized and directed line traffic against a line-array model.
module tb_pmem_line_responder;

  localparam int LAT   = 4;
  localparam int LINES = 256;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [15:0]  pmem_address = 16'd0;
  logic [127:0] pmem_wdata = 128'd0;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_error;
`ifdef PMEM_STATS_EN
  logic [15:0]  stat_reads;
  logic [15:0]  stat_writes;
`endif

  pmem_line_responder #(.LINES(LINES), .LATENCY(LAT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp),
    .pmem_error(pmem_error)
`ifdef PMEM_STATS_EN
    ,
    .stat_reads(stat_reads),
    .stat_writes(stat_writes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_read;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model [LINES];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           err_exp = 1'b0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && pmem_resp) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", pmem_resp, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", 128'(cyc), 128'(e.cyc));
        if (e.is_read) chk("rdata", pmem_rdata, e.data);
      end
    end
  end

  // mode 0: plain, 1: scramble address/wdata after acceptance, 2: switch read to write while busy
  task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                     input logic [127:0] wd, input int mode);
    exp_t e;
    bit   got;
    logic [7:0] idx;
    idx = addr[11:4];
    @(posedge clk); #1;
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
    e.is_read = !wr;
    e.data    = model[idx];
    e.cyc     = cyc + LAT;
    sb.push_back(e);
    if (wr) begin
      model[idx] = wd;
      wr_cnt++;
    end else begin
      rd_cnt++;
    end
    if (rd && wr) err_exp = 1'b1;
    if (mode == 2) err_exp = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (pmem_resp) begin
        got = 1'b1;
      end else if (k == 1 && mode == 1) begin
        pmem_address = 16'($urandom);
        pmem_wdata   = rand128();
      end else if (k == 1 && mode == 2) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b1;
        pmem_wdata = rand128();
      end
    end
    if (!got) chk("resp_timeout", pmem_resp, 128'd1);
    @(posedge clk); #1;
    pmem_read = 1'b0; pmem_write = 1'b0;
    if (!wr) begin
      @(negedge clk);
      chk("rdata_hold", pmem_rdata, e.data);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    err_exp = 1'b0; rd_cnt = 0; wr_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    logic [15:0]  a;
    int           cnt;
    exp_t         e;

    repeat (3) @(negedge clk);
    chk("reset_resp", pmem_resp, 128'd0);
    chk("reset_rdata", pmem_rdata, 128'd0);
    chk("reset_error", pmem_error, 128'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Preload every line that is read later.
    txn(1'b0, 1'b1, 16'h0200, 128'h0, 0);
    txn(1'b0, 1'b1, 16'h0400, rand128(), 0);
    for (int i = 0; i < 8; i++) txn(1'b0, 1'b1, 16'(16'h0500 + i * 16), rand128(), 0);

    txn(1'b0, 1'b1, 16'h0120, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C, 0);
    txn(1'b1, 1'b0, 16'h012F, 128'd0, 0);
    txn(1'b0, 1'b1, 16'h0010, 128'h1, 0);
    txn(1'b1, 1'b0, 16'h1010, 128'd0, 0);

    // Read held through TURN and beyond: second acceptance only after TURN.
    @(posedge clk); #1;
    pmem_read = 1'b1; pmem_address = 16'h0120;
    e.is_read = 1'b1; e.data = model[8'h12];
    e.cyc = cyc + LAT;         sb.push_back(e);
    e.cyc = cyc + 2 * LAT + 2; sb.push_back(e);
    rd_cnt += 2;
    cnt = 0;
    for (int k = 0; k < 80 && cnt < 2; k++) begin
      @(negedge clk);
      if (pmem_resp) cnt++;
    end
    if (cnt < 2) chk("held_timeout", 128'(cnt), 128'd2);
    @(posedge clk); #1 pmem_read = 1'b0;
    @(negedge clk);
    chk("err_clean", pmem_error, 128'(err_exp));

    for (int i = 0; i < 40; i++) begin
      a = 16'((($urandom_range(0, 15)) << 12) | ((8'h50 + $urandom_range(0, 7)) << 4) | $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) txn(1'b1, 1'b0, a, rand128(), $urandom_range(0, 1));
      else                           txn(1'b0, 1'b1, a, rand128(), $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    @(negedge clk);
    chk("err_after_random", pmem_error, 128'(err_exp));

    // Abort: write dropped in cycle 2.
    @(posedge clk); #1;
    pmem_write = 1'b1; pmem_address = 16'h0200; pmem_wdata = 128'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1 pmem_write = 1'b0;
    err_exp = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    chk("abort_error", pmem_error, 128'd1);
    txn(1'b1, 1'b0, 16'h0200, 128'd0, 0);

    // Reset in cycle 2 of a write.
    d = model[8'h40];
    @(posedge clk); #1;
    pmem_write = 1'b1; pmem_address = 16'h0400; pmem_wdata = ~d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0; pmem_write = 1'b0;
    #1;
    chk("midrst_resp", pmem_resp, 128'd0);
    chk("midrst_rdata", pmem_rdata, 128'd0);
    chk("midrst_error", pmem_error, 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b1;
    err_exp = 1'b0; rd_cnt = 0; wr_cnt = 0;
    txn(1'b1, 1'b0, 16'h0400, 128'd0, 0);
    chk("midrst_line", pmem_rdata, d);

    // Simultaneous read and write is serviced as a write.
    txn(1'b1, 1'b1, 16'h0300, 128'h5, 0);
    @(negedge clk);
    chk("rw_error", pmem_error, 128'd1);
    txn(1'b1, 1'b0, 16'h0300, 128'd0, 0);

    // Read switched to write while busy keeps the read.
    do_reset();
    @(negedge clk);
    chk("rst_error_clear", pmem_error, 128'd0);
    txn(1'b1, 1'b0, 16'h0500, 128'd0, 2);
    @(negedge clk);
    chk("switch_error", pmem_error, 128'(err_exp));

`ifdef PMEM_STATS_EN
    do_reset();
    txn(1'b1, 1'b0, 16'h0510, 128'd0, 0);
    txn(1'b0, 1'b1, 16'h0520, rand128(), 0);
    txn(1'b1, 1'b0, 16'h0530, 128'd0, 0);
    txn(1'b0, 1'b1, 16'h0540, rand128(), 0);
    txn(1'b1, 1'b0, 16'h0520, 128'd0, 0);
    @(negedge clk);
    chk("stat_reads", stat_reads, 128'(rd_cnt));
    chk("stat_writes", stat_writes, 128'(wr_cnt));
`endif

    repeat (LAT + 4) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
